// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter.
// Covers the FSM state encoding, the wait-counter type and the data-mux selector values.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int unsigned WAIT_DEFAULT = 2;
  localparam int unsigned CNT_W        = 4;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LS    = 1'b1;

  typedef logic [CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright.
// On a tie, the port that was not granted last wins.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_port
);

  assign grant_valid = req0 | req1;
  assign grant_port  = (req0 && req1) ? ~last_grant
                                      : (req1 ? PORT_LS : PORT_FETCH);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between fetch (port 0) and load/store (port 1).
// Runs a fixed-wait-state access, then returns registered read data with a one-cycle ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT   = WAIT_DEFAULT,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        state_q, state_d;
  wait_cnt_t         cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_valid, grant_port;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d      = ST_ACCESS;
          cnt_d        = wait_cnt_t'(WAIT - 1);
          sel_d        = grant_port;
          last_grant_d = grant_port;
          // The fetch port never writes, so its write enable and data are forced to zero.
          if (grant_port == PORT_LS) begin
            we_d    = we1;
            addr_d  = addr1;
            wdata_d = wdata1;
          end else begin
            we_d    = 1'b0;
            addr_d  = addr0;
            wdata_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - wait_cnt_t'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= PORT_LS;
      sel_q        <= PORT_FETCH;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Enable, write enable and acks decode from the registered state, so they are glitch-free.
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign ack0      = (state_q == ST_DONE) && (sel_q == PORT_FETCH);
  assign ack1      = (state_q == ST_DONE) && (sel_q == PORT_LS);
  assign sel       = sel_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// A round-robin reference model queues expected transactions, and a negedge monitor checks them.
module tb_mem_port_arbiter;

  localparam int W       = 2;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        reset, req0, req1, we1, memClear;
  logic [31:0] addr0, addr1, wdata1, memRdata;
  logic        ack0, ack1, sel, memEn, memWe;
  logic [31:0] rdata, memAddr, memWdata;

  logic        reqW [2];
  logic        ackW [2];
  logic        ack1W [2];
  logic        selW [2];
  logic        enW [2];
  logic        weW [2];
  logic [31:0] rdataW [2];
  logic [31:0] dataW [2];
  logic [31:0] addrW [2];
  logic [31:0] wdataW [2];

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackCycle;
  } txn_t;

  txn_t        expQ[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          accessCount = 0;
  bit          noScore = 1'b0;
  logic        lastGrant;
  logic [31:0] lastRdata;
  logic [31:0] modelMem [128];
  logic [31:0] devMem [128];
  logic [127:0] devWritten;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] initVal(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  mem_port_arbiter #(.WAIT(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .sel(sel), .mem_en(memEn), .mem_we(memWe),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata)
  );

  mem_port_arbiter #(.WAIT(1)) u_w1 (
    .clk(clk), .reset(reset),
    .req0(reqW[0]), .addr0(32'h200), .ack0(ackW[0]),
    .req1(1'b0), .we1(1'b0), .addr1(32'h0), .wdata1(32'h0), .ack1(ack1W[0]),
    .rdata(rdataW[0]), .sel(selW[0]), .mem_en(enW[0]), .mem_we(weW[0]),
    .mem_addr(addrW[0]), .mem_wdata(wdataW[0]), .mem_rdata(dataW[0])
  );

  mem_port_arbiter #(.WAIT(15)) u_w15 (
    .clk(clk), .reset(reset),
    .req0(reqW[1]), .addr0(32'h200), .ack0(ackW[1]),
    .req1(1'b0), .we1(1'b0), .addr1(32'h0), .wdata1(32'h0), .ack1(ack1W[1]),
    .rdata(rdataW[1]), .sel(selW[1]), .mem_en(enW[1]), .mem_we(weW[1]),
    .mem_addr(addrW[1]), .mem_wdata(wdataW[1]), .mem_rdata(dataW[1])
  );

  // Memory behind the port: unwritten words return initVal, and writes land on enabled edges.
  always @(posedge clk) begin
    if (memClear) begin
      devWritten <= '0;
    end else if (memEn && memWe) begin
      devWritten[memAddr[8:2]] <= 1'b1;
      devMem[memAddr[8:2]]     <= memWdata;
    end
  end

  always @(negedge clk) begin
    memRdata <= devWritten[memAddr[8:2]] ? devMem[memAddr[8:2]] : initVal(memAddr);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkZeros(input string tag);
    checkOutput({tag, "_sel"}, sel, 0);
    checkOutput({tag, "_mem_en"}, memEn, 0);
    checkOutput({tag, "_mem_we"}, memWe, 0);
    checkOutput({tag, "_mem_addr"}, memAddr, 0);
    checkOutput({tag, "_mem_wdata"}, memWdata, 0);
    checkOutput({tag, "_rdata"}, rdata, 0);
    checkOutput({tag, "_ack0"}, ack0, 0);
    checkOutput({tag, "_ack1"}, ack1, 0);
  endtask

  // Monitor: every ack pops one expected transaction; every enabled cycle is checked against the head.
  always @(negedge clk) begin
    txn_t e;
    checkOutput("ack_exclusive", {63'd0, ack0 & ack1}, 0);
    if (reset) begin
      accessCount = 0;
    end else if (memEn) begin
      accessCount++;
      if (!noScore) begin
        if (expQ.size() == 0) begin
          checkOutput("mem_en_unexpected", memEn, 0);
        end else begin
          checkOutput("mem_sel_we", {sel, memWe}, {expQ[0].port, expQ[0].we});
          checkOutput("mem_addr", memAddr, expQ[0].addr);
          checkOutput("mem_wdata", memWdata, expQ[0].wdata);
        end
      end
    end
    if (ack0 || ack1) begin
      if (expQ.size() == 0) begin
        checkOutput("ack_unexpected", {ack0, ack1}, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("ack_port", ack1, e.port);
        checkOutput("ack_cycle", 64'(cyc), 64'(e.ackCycle));
        checkOutput("ack_rdata", rdata, e.rdata);
        checkOutput("access_cycles", 64'(accessCount), 64'(W));
        checkOutput("mem_en_in_done", memEn, 0);
      end
      accessCount = 0;
    end
  end

  // Holds port 0 for n0 back-to-back transactions and port 1 for n1 transactions.
  // The model replays the same requests through the tie-break rule to predict grant order and ack cycles.
  task automatic applyStimulus(input int n0, input int n1, input logic [31:0] a0,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input logic w1, input bit resetMid);
    int   c, r0, r1, k, a0c, a1c;
    logic p;
    txn_t e;
    bit   done;
    @(negedge clk);
    if (resetMid) noScore = 1'b1;
    addr0 = a0; addr1 = a1; wdata1 = d1; we1 = w1;
    req0 = (n0 > 0); req1 = (n1 > 0);
    c = cyc;
    if (resetMid) begin
      @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checkZeros("reset_mid");
      #1 reset = 1'b0;
      expQ.delete();
      lastGrant = 1'b1;
      lastRdata = '0;
      noScore = 1'b0;
      c = cyc;
    end
    r0 = n0; r1 = n1; k = 0;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) p = ~lastGrant;
      else p = (r1 > 0);
      e.port  = p;
      e.we    = p ? w1 : 1'b0;
      e.addr  = p ? a1 : a0;
      e.wdata = p ? d1 : 32'h0;
      if (e.we) begin
        modelMem[a1[8:2]] = d1;
        e.rdata = lastRdata;
      end else begin
        e.rdata   = modelMem[e.addr[8:2]];
        lastRdata = e.rdata;
      end
      e.ackCycle = c + (k + 1) * (W + 1) + k;
      expQ.push_back(e);
      lastGrant = p;
      k++;
      if (p) r1--; else r0--;
    end
    a0c = 0; a1c = 0; done = 1'b0;
    for (int t = 0; t < TIMEOUT; t++) begin
      @(negedge clk);
      if (ack0) a0c++;
      if (ack1) a1c++;
      @(posedge clk);
      #1;
      if (a0c >= n0) req0 = 1'b0;
      if (a1c >= n1) req1 = 1'b0;
      if (a0c >= n0 && a1c >= n1) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("round_done", {63'd0, done}, 1);
    if (!done) begin
      req0 = 1'b0;
      req1 = 1'b0;
      expQ.delete();
    end
  endtask

  task automatic singleReadW(input int idx, input int w);
    int start, n;
    bit seen;
    @(negedge clk);
    reqW[idx] = 1'b1;
    start = cyc; n = 0; seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (enW[idx]) n++;
      if (ackW[idx]) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("w%0d_ack_seen", w), {63'd0, seen}, 1);
    checkOutput($sformatf("w%0d_latency", w), 64'(cyc - start), 64'(w + 1));
    checkOutput($sformatf("w%0d_rdata", w), rdataW[idx], dataW[idx]);
    checkOutput($sformatf("w%0d_en_cycles", w), 64'(n), 64'(w));
    checkOutput($sformatf("w%0d_side_outs", w), {ack1W[idx], weW[idx], selW[idx]}, 0);
    checkOutput($sformatf("w%0d_addr", w), addrW[idx], 32'h200);
    checkOutput($sformatf("w%0d_wdata", w), wdataW[idx], 0);
    @(posedge clk);
    #1 reqW[idx] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int          n0, n1;
    logic [31:0] a0, a1;
    reset = 1'b1; memClear = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata1 = '0;
    reqW[0] = 1'b0; reqW[1] = 1'b0;
    dataW[0] = 32'hA1A1_0001; dataW[1] = 32'hF15F_0015;
    lastGrant = 1'b1; lastRdata = '0;
    for (int i = 0; i < 128; i++) modelMem[i] = initVal(32'(i) << 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkZeros("reset");
    reset = 1'b0; memClear = 1'b0;

    applyStimulus(1, 0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1, 32'h0, 32'h40, 32'h12345678, 1'b1, 1'b0);
    applyStimulus(2, 0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1, 1, 32'h44, 32'h100, 32'hCAFEF00D, 1'b1, 1'b0);

    for (int r = 0; r < 40; r++) begin
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 == 0 && n1 == 0) n0 = 1;
      a0 = ($urandom_range(0, 3) == 0) ? 32'h100 : 32'h40 + 32'(4 * $urandom_range(0, 7));
      a1 = 32'h40 + 32'(4 * $urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      applyStimulus(n0, n1, a0, a1, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

    applyStimulus(2, 1, 32'h48, 32'h4C, 32'h0BADCAFE, 1'b0, 1'b1);
    applyStimulus(1, 1, 32'h50, 32'h54, 32'h55AA55AA, 1'b1, 1'b0);

    singleReadW(0, 1);
    singleReadW(1, 15);

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 64'(expQ.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
